// File: rtl/lane_traffic_ctrl.sv
// Multi-lane car traffic for the Frogg playfield: per-lane motion with wrap-around,
// speed levels, a registered car-draw pixel and a sticky frog/car collision flag.
module lane_traffic_ctrl #(
  parameter int unsigned c_GAME_WIDTH     = 40,
  parameter int unsigned c_GAME_HEIGHT    = 30,
  parameter int unsigned c_NUM_LANES      = 4,
  parameter int unsigned c_FIRST_LANE_ROW = 10,
  parameter int unsigned c_CAR_WIDTH      = 2,
  parameter int unsigned c_BASE_TICKS     = 1250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Game_Active,
  input  logic       i_Level_Up,
  input  logic [5:0] i_Col_Count_Div,
  input  logic [5:0] i_Row_Count_Div,
  input  logic [5:0] i_Frog_X,
  input  logic [5:0] i_Frog_Y,
  output logic       o_Draw_Car,
  output logic       o_Hit,
  output logic [1:0] o_Level
);

  localparam int unsigned CNT_W = $clog2(c_BASE_TICKS + 1);
  localparam logic [CNT_W-1:0] PERIOD_L0 = CNT_W'(c_BASE_TICKS);

  typedef enum logic [1:0] {IDLE, RUN, HIT} state_t;

  state_t           state;
  logic [5:0]       car_x [c_NUM_LANES];
  logic [2:0]       lane_div [c_NUM_LANES];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] base_period_c;
  logic             tick_c;
  logic             draw_c;
  logic             hit_c;

  function automatic logic [5:0] home_x(input int unsigned k);
    return 6'((k * 10) % c_GAME_WIDTH);
  endfunction

  // True when tile (col,row) lies under the car of lane k, including the wrapped part.
  function automatic logic occupies(input logic [5:0] col, input logic [5:0] row,
                                    input logic [5:0] car, input int unsigned k);
    logic [6:0] diff;
    if (row != 6'(c_FIRST_LANE_ROW + 2 * k) || row >= 6'(c_GAME_HEIGHT) ||
        col >= 6'(c_GAME_WIDTH))
      return 1'b0;
    if (col >= car) diff = 7'(col) - 7'(car);
    else            diff = 7'(col) + 7'(c_GAME_WIDTH) - 7'(car);
    return diff < 7'(c_CAR_WIDTH);
  endfunction

  function automatic logic [5:0] move_x(input logic [5:0] x, input logic right);
    if (right) return (x == 6'(c_GAME_WIDTH - 1)) ? 6'd0 : x + 6'd1;
    else       return (x == 6'd0) ? 6'(c_GAME_WIDTH - 1) : x - 6'd1;
  endfunction

  // Period for the current level; never zero so very high levels tick every clock.
  always_comb begin
    base_period_c = CNT_W'(c_BASE_TICKS >> o_Level);
    if (base_period_c == '0) base_period_c = CNT_W'(1);
  end

  assign tick_c = (state == RUN) && (cnt == period - CNT_W'(1));

  always_comb begin
    draw_c = 1'b0;
    hit_c  = 1'b0;
    for (int unsigned k = 0; k < c_NUM_LANES; k++) begin
      if (occupies(i_Col_Count_Div, i_Row_Count_Div, car_x[k], k)) draw_c = 1'b1;
      if (state == RUN && occupies(i_Frog_X, i_Frog_Y, car_x[k], k)) hit_c = 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      period     <= PERIOD_L0;
      o_Level    <= 2'd0;
      o_Draw_Car <= 1'b0;
      o_Hit      <= 1'b0;
      for (int unsigned k = 0; k < c_NUM_LANES; k++) begin
        car_x[k]    <= home_x(k);
        lane_div[k] <= 3'd0;
      end
    end else begin
      o_Draw_Car <= draw_c;
      if (i_Level_Up && o_Level != 2'd3) o_Level <= o_Level + 2'd1;

      case (state)
        IDLE: begin
          cnt    <= '0;
          period <= base_period_c;
          o_Hit  <= 1'b0;
          for (int unsigned k = 0; k < c_NUM_LANES; k++) begin
            car_x[k]    <= home_x(k);
            lane_div[k] <= 3'd0;
          end
          if (i_Game_Active) state <= RUN;
        end
        RUN: begin
          if (!i_Game_Active) begin
            state <= IDLE;
            cnt   <= '0;
            for (int unsigned k = 0; k < c_NUM_LANES; k++) begin
              car_x[k]    <= home_x(k);
              lane_div[k] <= 3'd0;
            end
          end else if (hit_c) begin
            // Collision wins over any move due on this edge.
            state <= HIT;
            o_Hit <= 1'b1;
          end else if (tick_c) begin
            cnt    <= '0;
            period <= base_period_c;
            for (int unsigned k = 0; k < c_NUM_LANES; k++) begin
              if (lane_div[k] == 3'(k % 4)) begin
                lane_div[k] <= 3'd0;
                car_x[k]    <= move_x(car_x[k], (k % 2) == 0);
              end else begin
                lane_div[k] <= lane_div[k] + 3'd1;
              end
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIT: begin
          if (!i_Game_Active) begin
            state <= IDLE;
            o_Hit <= 1'b0;
            cnt   <= '0;
            for (int unsigned k = 0; k < c_NUM_LANES; k++) begin
              car_x[k]    <= home_x(k);
              lane_div[k] <= 3'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Directed bench for lane_traffic_ctrl with a short base tick; car positions are
// observed by freezing traffic through a collision and scanning the draw output.
module tb_lane_traffic_ctrl;

  logic       clk = 1'b0;
  logic       rst, active, lvl_up;
  logic [5:0] col, row, fx, fy;
  logic       draw, hit;
  logic [1:0] level;
  int         vectors = 0;
  int         miscompares = 0;

  lane_traffic_ctrl #(
    .c_GAME_WIDTH(40), .c_GAME_HEIGHT(30), .c_NUM_LANES(4),
    .c_FIRST_LANE_ROW(10), .c_CAR_WIDTH(2), .c_BASE_TICKS(4)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Game_Active(active), .i_Level_Up(lvl_up),
    .i_Col_Count_Div(col), .i_Row_Count_Div(row), .i_Frog_X(fx), .i_Frog_Y(fy),
    .o_Draw_Car(draw), .o_Hit(hit), .o_Level(level)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scan(input int c, input int r, input logic e, input string tag);
    col = 6'(c);
    row = 6'(r);
    step(1);
    chk(tag, {7'd0, draw}, {7'd0, e});
  endtask

  initial begin
    rst = 1'b1; active = 1'b0; lvl_up = 1'b0;
    col = '0; row = '0; fx = '0; fy = '0;
    step(2);
    rst = 1'b0;
    chk("rst_hit", {7'd0, hit}, 8'd0);
    chk("rst_level", {6'd0, level}, 8'd0);
    chk("rst_draw", {7'd0, draw}, 8'd0);

    // Idle layout: X = {0,10,20,30}
    scan(10, 12, 1'b1, "idle_l1_10");
    scan(12, 12, 1'b0, "idle_l1_12");
    scan(0, 10, 1'b1, "idle_l0_0");
    scan(1, 10, 1'b1, "idle_l0_1");
    scan(2, 10, 1'b0, "idle_l0_2");
    scan(39, 10, 1'b0, "idle_l0_39");
    scan(20, 14, 1'b1, "idle_l2_20");
    scan(31, 16, 1'b1, "idle_l3_31");
    scan(32, 16, 1'b0, "idle_l3_32");
    scan(5, 11, 1'b0, "idle_gap_row");
    scan(0, 18, 1'b0, "idle_no_lane4");
    chk("idle_hit", {7'd0, hit}, 8'd0);

    // Speeds: 12 base ticks, then freeze by putting the frog on lane 0
    active = 1'b1;
    step(49);
    chk("spd_nohit", {7'd0, hit}, 8'd0);
    fx = 6'd12; fy = 6'd10;
    step(1);
    chk("spd_hit", {7'd0, hit}, 8'd1);
    scan(12, 10, 1'b1, "spd_l0_12");
    scan(11, 10, 1'b0, "spd_l0_11");
    scan(13, 10, 1'b1, "spd_l0_13");
    scan(14, 10, 1'b0, "spd_l0_14");
    scan(4, 12, 1'b1, "spd_l1_4");
    scan(3, 12, 1'b0, "spd_l1_3");
    scan(6, 12, 1'b0, "spd_l1_6");
    scan(24, 14, 1'b1, "spd_l2_24");
    scan(23, 14, 1'b0, "spd_l2_23");
    scan(27, 16, 1'b1, "spd_l3_27");
    scan(26, 16, 1'b0, "spd_l3_26");
    scan(29, 16, 1'b0, "spd_l3_29");
    chk("hit_sticky", {7'd0, hit}, 8'd1);
    active = 1'b0;
    step(1);
    chk("hit_clear", {7'd0, hit}, 8'd0);
    scan(0, 10, 1'b1, "restore_l0_0");
    scan(12, 10, 1'b0, "restore_l0_12");
    scan(10, 12, 1'b1, "restore_l1_10");

    // Lane 0 reaches X=39 after 39 moves and straddles the edge
    fx = 6'd0; fy = 6'd0; active = 1'b1;
    step(157);
    fx = 6'd39; fy = 6'd10;
    step(1);
    chk("w39_hit", {7'd0, hit}, 8'd1);
    scan(39, 10, 1'b1, "w39_39");
    scan(0, 10, 1'b1, "w39_0");
    scan(38, 10, 1'b0, "w39_38");
    scan(1, 10, 1'b0, "w39_1");
    active = 1'b0;
    step(1);

    // Lane 0: one more move from 39 wraps to 0
    fx = 6'd0; fy = 6'd0; active = 1'b1;
    step(157);
    fx = 6'd1; fy = 6'd10;
    step(4);
    chk("w0_nohit", {7'd0, hit}, 8'd0);
    step(1);
    chk("w0_hit", {7'd0, hit}, 8'd1);
    scan(0, 10, 1'b1, "w0_0");
    scan(1, 10, 1'b1, "w0_1");
    scan(39, 10, 1'b0, "w0_39");
    scan(2, 10, 1'b0, "w0_2");
    active = 1'b0;
    step(1);

    // Lane 1 wraps left from 0 to 39 on its 11th move (tick 22)
    fx = 6'd39; fy = 6'd12; active = 1'b1;
    step(89);
    chk("l1w_nohit", {7'd0, hit}, 8'd0);
    step(1);
    chk("l1w_hit", {7'd0, hit}, 8'd1);
    scan(39, 12, 1'b1, "l1w_39");
    scan(0, 12, 1'b1, "l1w_0");
    scan(38, 12, 1'b0, "l1w_38");
    scan(1, 12, 1'b0, "l1w_1");
    active = 1'b0;
    step(1);

    // Reset mid-run with a tick pending: the pending move must not land
    fx = 6'd0; fy = 6'd0; active = 1'b1;
    step(4);
    col = 6'd2; row = 6'd10; rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mrst_hit", {7'd0, hit}, 8'd0);
    step(1);
    chk("mrst_nomove", {7'd0, draw}, 8'd0);
    col = 6'd0;
    step(1);
    chk("mrst_home", {7'd0, draw}, 8'd1);
    active = 1'b0;
    step(1);

    // Level saturation, then lane 0 moves every clock
    lvl_up = 1'b1;
    step(1); chk("lvl_1", {6'd0, level}, 8'd1);
    step(1); chk("lvl_2", {6'd0, level}, 8'd2);
    step(1); chk("lvl_3", {6'd0, level}, 8'd3);
    step(1); chk("lvl_sat", {6'd0, level}, 8'd3);
    lvl_up = 1'b0;
    fx = 6'd3; fy = 6'd10; active = 1'b1;
    step(3);
    chk("lvl_nohit", {7'd0, hit}, 8'd0);
    step(1);
    chk("lvl_hit", {7'd0, hit}, 8'd1);
    scan(2, 10, 1'b1, "lvl_l0_2");
    scan(3, 10, 1'b1, "lvl_l0_3");
    scan(1, 10, 1'b0, "lvl_l0_1");
    scan(4, 10, 1'b0, "lvl_l0_4");
    chk("lvl_persist", {6'd0, level}, 8'd3);
    active = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("lvl_rst", {6'd0, level}, 8'd0);
    chk("lvl_rst_hit", {7'd0, hit}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lane_traffic_ctrl.md
Name: lane_traffic_ctrl

Overview:
- Generates and animates the car traffic of the Frogg playfield: c_NUM_LANES lanes, one car per lane, each lane with its own speed and direction.
- Sits directly upstream of the game top-level.
- Supplies a registered car-draw pixel and a registered frog/car collision flag, both in the 40x30 divided tile space.
- Replaces the single-car control with multi-lane traffic, wrap-around and speed levels.

Parameters:
- c_GAME_WIDTH, 40: playfield columns (tiles).
- c_GAME_HEIGHT, 30: playfield rows (tiles).
- c_NUM_LANES, 4: number of lanes, 1..8.
- c_FIRST_LANE_ROW, 10: tile row of lane 0; lane k sits at row c_FIRST_LANE_ROW + 2*k.
- c_CAR_WIDTH, 2: car width in tiles, 1..4.
- c_BASE_TICKS, 1250000: clocks per base tick at level 0 (50 ms at 25 MHz).

Ports:
- i_Clk  in  1  pixel clock
- i_Rst  in  1  synchronous active-high reset
- i_Game_Active  in  1  high while the game top is in RUNNING
- i_Level_Up  in  1  single-cycle pulse, raises speed level
- i_Col_Count_Div  in  6  current pixel column / 16
- i_Row_Count_Div  in  6  current pixel row / 16
- i_Frog_X  in  6  frog tile column
- i_Frog_Y  in  6  frog tile row
- o_Draw_Car  out  1  current tile belongs to a car
- o_Hit  out  1  frog overlaps a car (sticky)
- o_Level  out  2  current speed level

Behaviour:
- Reset (i_Rst=1 at a clock edge):
  - Car X[k] = (k*10) mod c_GAME_WIDTH.
  - Base counter = 0, lane dividers = 0, level = 0.
  - FSM = IDLE; o_Draw_Car = 0, o_Hit = 0, o_Level = 0.
  - Reset takes effect mid-run on the same edge, with priority over all other inputs.
- FSM states IDLE, RUN, HIT:
  - IDLE: cars held at reset X; counters held at 0; o_Hit = 0. Go to RUN when i_Game_Active = 1.
  - RUN: cars advance. If i_Game_Active = 0, go to IDLE (positions restored next cycle). If a collision is detected, go to HIT.
  - HIT: positions frozen; o_Hit = 1. Go to IDLE when i_Game_Active = 0.
- Base tick:
  - The counter counts 0..(c_BASE_TICKS >> level) - 1 in RUN only.
  - It emits a one-cycle tick on wrap.
  - Period is sampled at wrap, so a level change takes effect from the next period.
- Lane motion:
  - Lane k has a 3-bit divider; lane k moves one tile every (k mod 4)+1 base ticks.
  - Even lanes move right (+1); odd lanes move left (-1).
  - Wrap right: X = c_GAME_WIDTH-1 -> 0. Wrap left: X = 0 -> c_GAME_WIDTH-1.
  - Arithmetic is 6-bit; never emit X >= c_GAME_WIDTH.
- Car occupancy: lane k occupies row c_FIRST_LANE_ROW + 2k and columns X[k] .. X[k]+c_CAR_WIDTH-1 modulo c_GAME_WIDTH, so a car wraps across the edge and draws on both sides.
- o_Draw_Car:
  - Registered; 1-cycle latency from i_Col/Row_Count_Div.
  - High iff the sampled tile is occupied by any lane's car.
  - Active in every state, including IDLE.
- Collision:
  - Combinational compare of i_Frog_X/Y against the current registered positions (pre-update on a move cycle).
  - Evaluated only in RUN.
  - o_Hit rises on the cycle after detection and stays high through HIT.
  - A move and a collision on the same edge: HIT wins and the move is discarded.
- Level:
  - i_Level_Up increments the level, saturating at 3.
  - Level is cleared only by i_Rst and persists across games.
  - o_Level = level register.
- Rows outside the lanes and frog rows outside the lanes never assert draw or hit.

Test Plan:
- Reset then idle: i_Rst for 2 cycles, i_Game_Active = 0 -> o_Hit = 0, o_Level = 0, X = {0,10,20,30}. Scanning tile (10,12) gives o_Draw_Car = 1 one cycle later; tile (12,12) gives 0.
- Speeds (c_BASE_TICKS = 4): activate for 48 clocks (12 base ticks) -> lane 0 X = 12, lane 1 X = 4, lane 2 X = 24, lane 3 X = 27.
- Wrap: lane 0 at X = 39 plus one move -> X = 0. At X = 39, tiles (39,10) and (0,10) both draw. Lane 1 at X = 0 plus one move -> X = 39.
- Collision: frog at (21,14), lane 2 at X = 20 -> o_Hit = 1 next cycle; positions frozen. Drop i_Game_Active -> IDLE, o_Hit = 0, X restored.
- Level: four i_Level_Up pulses -> o_Level = 3 (saturated). Lane 0 then moves every c_BASE_TICKS >> 3 clocks; an i_Rst pulse -> o_Level = 0.
- Reset mid-run: assert i_Rst while in RUN with a tick pending -> next cycle is IDLE with reset positions; no move is applied.
